seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial sequence detector: watches a 1-bit input stream and flags every occurrence of an N-bit pattern. It generalises the team's fixed 2-flip-flop "110" Mealy detector:
- pattern length and value are parameters;
- the pattern can be reloaded at run time;
- Mealy or Moore output timing is selectable;
- overlapping or non-overlapping matching is selectable;
- a saturating match counter is included.

It sits between a serial bit source and control logic that consumes match pulses.

## Interface
- N, 3: pattern length in bits, N ≥ 2.
- PATTERN, 3'b110: reset/default pattern. PATTERN[N-1] is the first bit expected on x.
- MOORE, 0: output timing. 0 = Mealy, 1 = Moore.
- OVERLAP, 1: matching mode. 1 = overlapping matches allowed; 0 = after a match, matching restarts from scratch.
- CNT_W, 8: width of the match counter.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  bit-valid; x is consumed only in cycles with en=1.
- x  in  1  serial data bit.
- load  in  1  when high, pat_in replaces the active pattern.
- pat_in  in  N  new pattern, same bit ordering as PATTERN.
- clr_count  in  1  synchronous clear of match_count.
- y  out  1  match indication.
- match_count  out  CNT_W  number of matches since reset/clear, saturating.
- state  out  clog2(N+1)  current FSM state, for debug.

## Operation
**FSM meaning.** State k (0..N-1) = length of the longest suffix of consumed bits that equals the first k bits of the active pattern. Moore adds state N = "match just completed".

**Consuming a bit (en=1, load=0), from state k < N:**
- If x equals pattern bit N-1-k, go to k+1.
- Otherwise go to the longest border-based fallback: the largest j < k+1 such that the last j consumed bits, including x, equal the first j pattern bits. This is KMP failure logic, computed combinationally from the pattern register.

**Match completion**, i.e. the transition that would reach k = N:
- Mealy: y=1 in that same cycle. Next state is F(N) if OVERLAP=1, else 0. F(N) = longest proper prefix of the pattern that is also a suffix of it.
- Moore: next state is N; y=1 while state == N.
- Moore, leaving state N on the next en=1 bit: treat as coming from state F(N) if OVERLAP=1, else from state 0.

**en=0:** state holds.
- Mealy: y=0.
- Moore: y holds its decoded value, so state N keeps y=1 until the next consumed bit.

**load=1:**
- Pattern register ← pat_in; state ← 0.
- x is ignored that cycle and y=0 that cycle.
- match_count is unaffected.

**match_count:**
- +1 on the clock edge of each match event. The match event is the completion transition in both modes.
- Saturates at 2^CNT_W − 1.
- clr_count=1 forces it to 0, and takes priority over a simultaneous match.

**Reset (rst=1):**
- state ← 0, pattern ← PATTERN, match_count ← 0.
- y forced 0 in any cycle with rst=1.
- rst has priority over load, clr_count and en.
- A sequence partially received before a mid-stream reset is discarded.

## Timing
- Mealy y is combinational from x, en, load, rst and state: asserted in the same cycle as the final pattern bit.
- Moore y is decoded from registered state: asserted the cycle after the final bit's edge.
- match_count reflects a match one cycle after the match event (both modes).
- New pattern is active for the first bit consumed after the load edge.
- All outputs after reset: y=0, match_count=0, state=0.
- Throughput: one bit per cycle with en held high. No back-pressure.

## Test plan
1. **Default config (110, Mealy, overlap)**
   - Stimulus: en=1, x = 1,1,0,1,1,1,0.
   - Required: y=1 only on cycle 3 and cycle 7; match_count=2 after cycle 8.
2. **Overlap vs non-overlap, pattern 101 via load**
   - Stimulus: x = 1,0,1,0,1.
   - OVERLAP=1: y on bits 3 and 5, count=2.
   - OVERLAP=0: y on bit 3 only, count=1.
3. **Moore mode, default pattern**
   - Stimulus: 1,1,0, then en=0 for 2 cycles, then x=1.
   - Required: y=1 starting the cycle after bit 3, held through both en=0 cycles, 0 after the next consumed bit; state goes 0→1→2→3→3→3→1.
4. **Reset and load mid-sequence**
   - Stimulus: 1,1 then rst for 1 cycle, then 0.
   - Required: no match, state=0, count=0.
   - Stimulus: 1,1 then load pat_in=3'b011, then 0,1,1.
   - Required: y on the final 1 only.
5. **Counter saturation and clear priority**
   - Setup: CNT_W=2.
   - Stimulus: 4 matches.
   - Required: count=3 and stays 3.
   - Stimulus: clr_count asserted in the same cycle as a match.
   - Required: count=0 next cycle.
6. **en gaps**
   - Stimulus: pattern 110 with en=0 cycles inserted between each bit, x toggling randomly while en=0.
   - Required: single match at the third consumed bit; state unchanged during gaps.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time reloadable N-bit pattern, KMP fallback,
// selectable Mealy/Moore timing, overlap mode and a saturating match counter.
module seq_detector_param #(
    parameter int           N       = 3,
    parameter logic [N-1:0] PATTERN = 3'b110,
    parameter bit           MOORE   = 1'b0,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       x,
    input  logic                       load,
    input  logic [N-1:0]               pat_in,
    input  logic                       clr_count,
    output logic                       y,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(N+1)-1:0]     state
);

    localparam int                SW        = $clog2(N + 1);
    localparam logic [SW-1:0]     S_MATCH   = SW'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // State is a prefix length of the active pattern, so it stays numeric
    // rather than an enum; S_MATCH is only reachable in Moore mode.
    logic [N-1:0]     r_pattern;
    logic [SW-1:0]    r_state;
    logic [CNT_W-1:0] r_count;

    logic [SW-1:0]    w_next_state;
    logic [SW-1:0]    w_border;
    logic [SW-1:0]    w_from;
    logic [SW-1:0]    w_step;
    logic             w_match;
    logic             w_y;

    // Bit 'pos' of the pattern in arrival order (pos 0 is the first bit on x).
    function automatic logic pat_bit(input logic [N-1:0] pat, input int pos);
        logic [N-1:0] sh;
        sh = pat >> (N - 1 - pos);
        return sh[0];
    endfunction

    // Longest j <= k+1 such that (first k pattern bits, then xb) ends with
    // the first j pattern bits.
    function automatic logic [SW-1:0] f_step(input logic [N-1:0] pat, input int k,
                                             input logic xb);
        logic [SW-1:0] best;
        logic          ok;
        logic          sb;
        int            idx;
        best = '0;
        for (int j = 1; j <= N; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (i < j) begin
                        idx = k + 1 - j + i;
                        sb  = (idx == k) ? xb : pat_bit(pat, idx);
                        if (sb != pat_bit(pat, i)) ok = 1'b0;
                    end
                end
                if (ok) best = SW'(j);
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic logic [SW-1:0] f_border(input logic [N-1:0] pat);
        logic [SW-1:0] best;
        logic          ok;
        best = '0;
        for (int j = 1; j < N; j++) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i < j && pat_bit(pat, i) != pat_bit(pat, N - j + i)) ok = 1'b0;
            end
            if (ok) best = SW'(j);
        end
        return best;
    endfunction

    always_comb begin
        w_border = f_border(r_pattern);
        w_from   = r_state;
        if (MOORE && r_state == S_MATCH) begin
            w_from = OVERLAP ? w_border : '0;
        end
        w_step = f_step(r_pattern, int'(w_from), x);
    end

    always_comb begin
        w_next_state = r_state;
        w_match      = 1'b0;
        w_y          = 1'b0;
        if (load) begin
            w_next_state = '0;
        end else if (en) begin
            if (w_step == S_MATCH) begin
                w_match = 1'b1;
                if (MOORE)        w_next_state = S_MATCH;
                else if (OVERLAP) w_next_state = w_border;
                else              w_next_state = '0;
            end else begin
                w_next_state = w_step;
            end
        end
        if (MOORE) w_y = (r_state == S_MATCH) && !load && !rst;
        else       w_y = w_match && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= '0;
            r_pattern <= PATTERN;
            r_count   <= '0;
        end else begin
            r_state <= w_next_state;
            if (load) r_pattern <= pat_in;
            if (clr_count) begin
                r_count <= '0;
            end else if (w_match && r_count != CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign y           = w_y;
    assign match_count = r_count;
    assign state       = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four configurations share one stimulus stream and
// are checked every cycle against a history-based model plus directed literals.
module tb_seq_detector_param;

    localparam int N    = 3;
    localparam int MASK = (1 << N) - 1;

    logic       clk = 1'b0;
    logic       rst, en, x, load, clr_count;
    logic [2:0] pat_in;

    logic       y_a, y_b, y_c, y_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;
    logic [1:0] st_a, st_b, st_c, st_d;

    always #5 clk = ~clk;

    // a: Mealy overlap, b: Mealy non-overlap, c: Moore overlap, d: Moore non-overlap 2-bit count
    seq_detector_param #(.N(3), .PATTERN(3'b110), .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .clr_count(clr_count), .y(y_a), .match_count(cnt_a), .state(st_a));
    seq_detector_param #(.N(3), .PATTERN(3'b110), .MOORE(1'b0), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .clr_count(clr_count), .y(y_b), .match_count(cnt_b), .state(st_b));
    seq_detector_param #(.N(3), .PATTERN(3'b110), .MOORE(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .clr_count(clr_count), .y(y_c), .match_count(cnt_c), .state(st_c));
    seq_detector_param #(.N(3), .PATTERN(3'b110), .MOORE(1'b1), .OVERLAP(1'b0), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .clr_count(clr_count), .y(y_d), .match_count(cnt_d), .state(st_d));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per configuration, the last N consumed bits since reset/load/restart.
    bit m_moore[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit m_ovl[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    int m_max[4]   = '{255, 255, 255, 3};
    int m_hist[4]  = '{default: 0};
    int m_len[4]   = '{default: 0};
    int m_cnt[4]   = '{default: 0};
    bit m_flag[4]  = '{default: 1'b0};
    int m_pat      = 6;

    function automatic int longest(input int h, input int len, input int p);
        for (int j = N - 1; j >= 1; j--) begin
            if (j <= len && (h & ((1 << j) - 1)) == (p >> (N - j))) return j;
        end
        return 0;
    endfunction

    function automatic bit completes(input int h, input int len, input logic xb, input int p);
        int nh;
        nh = ((h << 1) | int'(xb)) & MASK;
        return (len + 1 >= N) && (nh == p);
    endfunction

    function automatic int exp_state(input int i);
        if (m_moore[i] && m_flag[i]) return N;
        return longest(m_hist[i], m_len[i], m_pat);
    endfunction

    function automatic int exp_y(input int i);
        if (rst || load) return 0;
        if (m_moore[i]) return int'(m_flag[i]);
        return int'(en && completes(m_hist[i], m_len[i], x, m_pat));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int h, l, c;
            bit f, hit;
            h = m_hist[i]; l = m_len[i]; c = m_cnt[i]; f = m_flag[i];
            hit = 1'b0;
            if (rst) begin
                h = 0; l = 0; c = 0; f = 1'b0;
            end else begin
                if (!load && en) hit = completes(h, l, x, m_pat);
                if (clr_count)                c = 0;
                else if (hit && c < m_max[i]) c = c + 1;
                if (load) begin
                    h = 0; l = 0; f = 1'b0;
                end else if (en) begin
                    f = hit && m_moore[i];
                    if (hit && !m_ovl[i]) begin
                        h = 0; l = 0;
                    end else begin
                        h = ((h << 1) | int'(x)) & MASK;
                        l = (l + 1 > N) ? N : l + 1;
                    end
                end
            end
            m_hist[i] <= h; m_len[i] <= l; m_cnt[i] <= c; m_flag[i] <= f;
        end
        if (rst)       m_pat <= 6;
        else if (load) m_pat <= int'(pat_in);
    end

    always @(negedge clk) begin
        chk("y_a", y_a, exp_y(0));   chk("st_a", st_a, exp_state(0)); chk("cnt_a", cnt_a, m_cnt[0]);
        chk("y_b", y_b, exp_y(1));   chk("st_b", st_b, exp_state(1)); chk("cnt_b", cnt_b, m_cnt[1]);
        chk("y_c", y_c, exp_y(2));   chk("st_c", st_c, exp_state(2)); chk("cnt_c", cnt_c, m_cnt[2]);
        chk("y_d", y_d, exp_y(3));   chk("st_d", st_d, exp_state(3)); chk("cnt_d", cnt_d, m_cnt[3]);
    end

    // Mid-cycle snapshot of outputs, for the directed literal checks.
    logic [3:0] s_y;
    logic [1:0] s_st_a, s_st_c;

    task automatic cyc(input logic e, input logic xv, input logic ld = 1'b0,
                       input logic [2:0] pi = 3'b000, input logic cl = 1'b0,
                       input logic r = 1'b0);
        rst = r; en = e; x = xv; load = ld; pat_in = pi; clr_count = cl;
        @(negedge clk);
        #1;
        s_y    = {y_d, y_c, y_b, y_a};
        s_st_a = st_a;
        s_st_c = st_c;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] t1_bits  = 7'b1101110;
    logic [6:0] t1_y     = 7'b0010001;
    logic [4:0] t2_bits  = 5'b10101;
    logic [4:0] t2_ya    = 5'b00101;
    logic [4:0] t2_yb    = 5'b00100;
    logic [5:0] t3_en    = 6'b111001;
    logic [5:0] t3_x     = 6'b110001;
    logic [5:0] t3_yc    = 6'b000111;
    logic [5:0] t3_ya    = 6'b001000;
    int         t3_st[6] = '{0, 1, 2, 3, 3, 3};
    logic [2:0] t4_bits  = 3'b011;
    logic [2:0] t4_y     = 3'b001;
    logic [2:0] t6_bits  = 3'b110;
    logic [2:0] t6_y     = 3'b001;
    int         t6_st[3] = '{1, 2, 0};

    initial begin
        rst = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; pat_in = 3'b000; clr_count = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, 1);
        chk("reset_state", st_a, 0);
        chk("reset_count", cnt_a, 0);
        chk("reset_y", y_a, 0);

        // Default pattern 110, Mealy overlap
        for (int k = 0; k < 7; k++) begin
            cyc(1, t1_bits[6-k]);
            chk("t1_y", s_y[0], t1_y[6-k]);
        end
        chk("t1_count", cnt_a, 2);

        // Load 101, overlap vs non-overlap
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 1, 3'b101);
        chk("t2_load_state", st_a, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, t2_bits[4-k]);
            chk("t2_y_ovl", s_y[0], t2_ya[4-k]);
            chk("t2_y_novl", s_y[1], t2_yb[4-k]);
        end
        chk("t2_count_ovl", cnt_a, 2);
        chk("t2_count_novl", cnt_b, 1);

        // Moore timing with en gaps after the match
        cyc(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            cyc(t3_en[5-k], t3_x[5-k]);
            chk("t3_moore_y", s_y[2], t3_yc[5-k]);
            chk("t3_moore_state", s_st_c, t3_st[k]);
            chk("t3_mealy_y", s_y[0], t3_ya[5-k]);
        end
        chk("t3_moore_state_end", st_c, 1);
        chk("t3_moore_y_end", y_c, 0);

        // Mid-sequence reset, then mid-sequence load
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("t4_rst_y", s_y[0], 0);
        cyc(1, 0);
        chk("t4_after_rst_y", s_y[0], 0);
        chk("t4_after_rst_state", st_a, 0);
        chk("t4_after_rst_count", cnt_a, 0);
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 0, 1, 3'b011);
        chk("t4_load_y", s_y[0], 0);
        chk("t4_load_count", cnt_a, 0);
        chk("t4_load_state", st_a, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, t4_bits[2-k]);
            chk("t4_new_pat_y", s_y[0], t4_y[2-k]);
        end
        chk("t4_count", cnt_a, 1);

        // Saturation on the 2-bit counter, then clear versus match
        cyc(0, 0, 0, 0, 0, 1);
        for (int m = 0; m < 4; m++) begin
            cyc(1, 1); cyc(1, 1); cyc(1, 0);
        end
        chk("t5_sat", cnt_d, 3);
        chk("t5_wide", cnt_a, 4);
        cyc(1, 1); cyc(1, 1); cyc(1, 0);
        chk("t5_sat_hold", cnt_d, 3);
        cyc(1, 1); cyc(1, 1); cyc(1, 0, 0, 0, 1);
        chk("t5_clr_match_y", s_y[0], 1);
        chk("t5_clr_wide", cnt_a, 0);
        chk("t5_clr_sat", cnt_d, 0);
        cyc(1, 1); cyc(1, 1); cyc(1, 0);
        chk("t5_after_clr", cnt_a, 1);

        // en gaps with x toggling while idle
        cyc(0, 0, 0, 0, 0, 1);
        for (int b = 0; b < 3; b++) begin
            cyc(1, t6_bits[2-b]);
            chk("t6_bit_y", s_y[0], t6_y[2-b]);
            for (int g = 0; g < 2; g++) begin
                cyc(0, 1'($urandom_range(0, 1)));
                chk("t6_gap_state", s_st_a, t6_st[b]);
                chk("t6_gap_y", s_y[0], 0);
            end
        end
        chk("t6_count", cnt_a, 1);

        // Mixed traffic with occasional reloads, clears and resets
        cyc(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 120; k++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
